bcd_countdown_timer: RTL and testbench

//   Loadable multi-decade BCD down counter with run/stop control and a terminal-count pulse.
//   It is the count-down counterpart of the multi-decade up counter: a preset is loaded in BCD
//   and decremented toward zero, with a borrow chain running across the decades.
//   It is used for countdown timers and delay generators, and drives the same BCD display path.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_countdown_timer_if.sv | 29 ++
 rtl/bcd_down_digit.sv | 37 +++
 rtl/bcd_countdown_timer.sv | 116 +++++++++++
 tb/tb_bcd_countdown_timer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, timer state encoding and digit check
package bcd_pkg;

    localparam int               BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED
    } timer_state_t;

    function automatic logic is_bcd(input logic [BCD_W-1:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// rtl/bcd_countdown_timer_if.sv - control and display bundle of the BCD countdown timer
interface bcd_countdown_timer_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3
);

    logic                      load;
    logic [BCD_W*DIGITS-1:0]   load_value;
    logic                      start;
    logic                      stop;
    logic                      enable;
    logic [BCD_W*DIGITS-1:0]   digits;
    logic                      done;
    logic                      zero;
    logic                      busy;
    logic                      load_err;

    modport master (
        output load, load_value, start, stop, enable,
        input  digits, done, zero, busy, load_err
    );

    modport slave (
        input  load, load_value, start, stop, enable,
        output digits, done, zero, busy, load_err
    );

endinterface

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD decade of the down counter with borrow output
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dec,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_val,
    output logic [BCD_W-1:0] q,
    output logic             borrow_out
);

    logic [BCD_W-1:0] val_q;
    logic [BCD_W-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (ld) begin
            val_d = ld_val;
        end else if (dec) begin
            val_d = (val_q == '0) ? BCD_MAX : val_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q          = val_q;
    assign borrow_out = dec & (val_q == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - loadable multi-decade BCD down counter with run/stop and terminal pulse
module bcd_countdown_timer
    import bcd_pkg::*;
#(
    parameter int DIGITS      = 3,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    bcd_countdown_timer_if.slave bus
);

    localparam int           W   = BCD_W * DIGITS;
    localparam logic [W-1:0] ONE = W'(1);

    timer_state_t state_q, state_d;
    logic [W-1:0] preset_q, preset_d;
    logic         done_q, done_d;
    logic         load_err_q, load_err_d;
    logic [W-1:0] digits_w;
    logic [W-1:0] ld_val;
    logic         load_ok;
    logic         ld;
    logic         dec_en;

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(bus.load_value[i*BCD_W +: BCD_W])) begin
                load_ok = 1'b0;
            end
        end
    end

    // Strict priority: an asserted higher input blocks the lower ones even if it has no effect.
    always_comb begin
        state_d    = state_q;
        preset_d   = preset_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        ld         = 1'b0;
        ld_val     = bus.load_value;
        dec_en     = 1'b0;
        if (bus.load) begin
            if (load_ok) begin
                ld       = 1'b1;
                preset_d = bus.load_value;
                state_d  = IDLE;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.stop) begin
            if (state_q == RUN) begin
                state_d = IDLE;
            end
        end else if (bus.start) begin
            if (state_q == IDLE && digits_w != '0) begin
                state_d = RUN;
            end
        end else if (bus.enable && state_q == RUN) begin
            dec_en = 1'b1;
            if (digits_w == ONE) begin
                done_d = 1'b1;
                if (AUTO_RELOAD) begin
                    ld     = 1'b1;
                    ld_val = preset_q;
                end else begin
                    state_d = EXPIRED;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            preset_q   <= '0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            preset_q   <= preset_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic dec_in;
        logic bout;
        if (i == 0) begin : g_lsd
            assign dec_in = dec_en;
        end else begin : g_chain
            assign dec_in = g_digit[i-1].bout;
        end
        bcd_down_digit u_digit (
            .clk        (clk),
            .reset_n    (reset_n),
            .dec        (dec_in),
            .ld         (ld),
            .ld_val     (ld_val[i*BCD_W +: BCD_W]),
            .q          (digits_w[i*BCD_W +: BCD_W]),
            .borrow_out (bout)
        );
    end

    // A borrow out of the top decade would mean RUN at zero, which start gating rules out.
    underflow_a: assert property (@(posedge clk) disable iff (!reset_n) !g_digit[DIGITS-1].bout);

    assign bus.digits   = digits_w;
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;
    assign bus.zero     = (digits_w == '0);
    assign bus.busy     = (state_q == RUN);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - self-checking bench for bcd_countdown_timer, both reload modes
module tb_bcd_countdown_timer;

    localparam int D      = 3;
    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_EXP  = 2;

    typedef struct {
        int val;
        int preset;
        int st;
        bit done;
        bit lerr;
    } model_t;

    typedef struct {
        bit          ld;
        logic [11:0] lv;
        bit          st;
        bit          sp;
        bit          en;
        logic [11:0] exp_digits;
        bit          exp_done;
        bit          exp_zero;
        bit          exp_busy;
        bit          exp_lerr;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    bcd_countdown_timer_if #(.DIGITS(D)) if0 ();
    bcd_countdown_timer_if #(.DIGITS(D)) if1 ();

    bcd_countdown_timer #(.DIGITS(D), .AUTO_RELOAD(1'b0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if0)
    );

    bcd_countdown_timer #(.DIGITS(D), .AUTO_RELOAD(1'b1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if1)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_err = 0;
    model_t m0;
    model_t m1;
    vec_t   tbl[$];

    function automatic int bcd2int(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [11:0] int2bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'((v / 100) % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [11:0] b);
        return (b[11:8] < 4'd10) && (b[7:4] < 4'd10) && (b[3:0] < 4'd10);
    endfunction

    task automatic model_step(inout model_t m, input bit ar, input bit rstn, input bit ld,
                              input logic [11:0] lv, input bit st, input bit sp, input bit en);
        m.done = 1'b0;
        m.lerr = 1'b0;
        if (!rstn) begin
            m.val    = 0;
            m.preset = 0;
            m.st     = S_IDLE;
        end else if (ld) begin
            if (bcd_ok(lv)) begin
                m.val    = bcd2int(lv);
                m.preset = m.val;
                m.st     = S_IDLE;
            end else begin
                m.lerr = 1'b1;
            end
        end else if (sp) begin
            if (m.st == S_RUN) m.st = S_IDLE;
        end else if (st) begin
            if (m.st == S_IDLE && m.val != 0) m.st = S_RUN;
        end else if (en && m.st == S_RUN) begin
            if (m.val == 1) begin
                m.done = 1'b1;
                if (ar) begin
                    m.val = m.preset;
                end else begin
                    m.val = 0;
                    m.st  = S_EXP;
                end
            end else begin
                m.val = m.val - 1;
            end
        end
    endtask

    task automatic check(input string name, input int dut, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h want %0h", name, dut, act, exp);
        end
    endtask

    task automatic check_dut(input int dut, input model_t m);
        logic [11:0] dg;
        logic        dn, z, b, le;
        if (dut == 0) begin
            dg = if0.digits; dn = if0.done; z = if0.zero; b = if0.busy; le = if0.load_err;
        end else begin
            dg = if1.digits; dn = if1.done; z = if1.zero; b = if1.busy; le = if1.load_err;
        end
        check("model_digits", dut, 32'(dg), 32'(int2bcd(m.val)));
        check("model_done", dut, 32'(dn), 32'(m.done));
        check("model_zero", dut, 32'(z), 32'(m.val == 0));
        check("model_busy", dut, 32'(b), 32'(m.st == S_RUN));
        check("model_load_err", dut, 32'(le), 32'(m.lerr));
    endtask

    task automatic cycle(input bit rstn, input bit ld, input logic [11:0] lv,
                         input bit st, input bit sp, input bit en);
        reset_n        = rstn;
        if0.load       = ld;  if1.load       = ld;
        if0.load_value = lv;  if1.load_value = lv;
        if0.start      = st;  if1.start      = st;
        if0.stop       = sp;  if1.stop       = sp;
        if0.enable     = en;  if1.enable     = en;
        @(posedge clk);
        model_step(m0, 1'b0, rstn, ld, lv, st, sp, en);
        model_step(m1, 1'b1, rstn, ld, lv, st, sp, en);
        #1;
        check_dut(0, m0);
        check_dut(1, m1);
    endtask

    initial begin
        int dones;

        // Reset wins over a simultaneous load
        cycle(1'b0, 1'b1, 12'h123, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 12'h123, 1'b0, 1'b0, 1'b0);
        check("rst_digits", 0, 32'(if0.digits), 32'h000);
        check("rst_zero", 0, 32'(if0.zero), 32'd1);
        check("rst_busy", 0, 32'(if0.busy), 32'd0);
        check("rst_done", 0, 32'(if0.done), 32'd0);
        check("rst_load_err", 0, 32'(if0.load_err), 32'd0);

        //                ld  lv       st sp en  digits   dn z  b  le
        tbl.push_back('{1, 12'h123, 0, 0, 0, 12'h123, 0, 0, 0, 0});
        tbl.push_back('{0, 12'h000, 1, 0, 0, 12'h123, 0, 0, 1, 0});
        tbl.push_back('{0, 12'h000, 0, 0, 1, 12'h122, 0, 0, 1, 0});
        tbl.push_back('{0, 12'h000, 0, 0, 1, 12'h121, 0, 0, 1, 0});
        tbl.push_back('{0, 12'h000, 0, 0, 1, 12'h120, 0, 0, 1, 0});
        tbl.push_back('{0, 12'h000, 0, 0, 1, 12'h119, 0, 0, 1, 0});
        tbl.push_back('{0, 12'h000, 0, 1, 1, 12'h119, 0, 0, 0, 0});
        tbl.push_back('{1, 12'h1A3, 0, 0, 0, 12'h119, 0, 0, 0, 1});
        tbl.push_back('{0, 12'h000, 0, 0, 0, 12'h119, 0, 0, 0, 0});
        tbl.push_back('{1, 12'h100, 0, 0, 0, 12'h100, 0, 0, 0, 0});
        tbl.push_back('{0, 12'h000, 1, 0, 0, 12'h100, 0, 0, 1, 0});
        tbl.push_back('{0, 12'h000, 0, 0, 1, 12'h099, 0, 0, 1, 0});
        tbl.push_back('{1, 12'h045, 0, 0, 1, 12'h045, 0, 0, 0, 0});
        tbl.push_back('{1, 12'h1A3, 0, 0, 0, 12'h045, 0, 0, 0, 1});
        tbl.push_back('{1, 12'h010, 0, 0, 0, 12'h010, 0, 0, 0, 0});
        tbl.push_back('{0, 12'h000, 1, 0, 0, 12'h010, 0, 0, 1, 0});
        tbl.push_back('{0, 12'h000, 0, 0, 1, 12'h009, 0, 0, 1, 0});
        tbl.push_back('{1, 12'h001, 0, 0, 0, 12'h001, 0, 0, 0, 0});
        tbl.push_back('{0, 12'h000, 1, 0, 0, 12'h001, 0, 0, 1, 0});
        tbl.push_back('{0, 12'h000, 0, 0, 1, 12'h000, 1, 1, 0, 0});
        tbl.push_back('{0, 12'h000, 0, 0, 0, 12'h000, 0, 1, 0, 0});
        tbl.push_back('{0, 12'h000, 1, 0, 0, 12'h000, 0, 1, 0, 0});
        tbl.push_back('{0, 12'h000, 0, 0, 1, 12'h000, 0, 1, 0, 0});
        tbl.push_back('{1, 12'h9F0, 0, 0, 0, 12'h000, 0, 1, 0, 1});
        tbl.push_back('{0, 12'h000, 1, 0, 0, 12'h000, 0, 1, 0, 0});
        tbl.push_back('{1, 12'h000, 0, 0, 0, 12'h000, 0, 1, 0, 0});
        tbl.push_back('{0, 12'h000, 1, 0, 0, 12'h000, 0, 1, 0, 0});
        tbl.push_back('{1, 12'h999, 0, 0, 0, 12'h999, 0, 0, 0, 0});
        tbl.push_back('{0, 12'h000, 1, 0, 0, 12'h999, 0, 0, 1, 0});
        tbl.push_back('{0, 12'h000, 0, 0, 1, 12'h998, 0, 0, 1, 0});

        foreach (tbl[i]) begin
            cycle(1'b1, tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].sp, tbl[i].en);
            check($sformatf("vec%0d_digits", i), 0, 32'(if0.digits), 32'(tbl[i].exp_digits));
            check($sformatf("vec%0d_done", i), 0, 32'(if0.done), 32'(tbl[i].exp_done));
            check($sformatf("vec%0d_zero", i), 0, 32'(if0.zero), 32'(tbl[i].exp_zero));
            check($sformatf("vec%0d_busy", i), 0, 32'(if0.busy), 32'(tbl[i].exp_busy));
            check($sformatf("vec%0d_load_err", i), 0, 32'(if0.load_err), 32'(tbl[i].exp_lerr));
        end

        // Full count from 123 with continuous enable
        cycle(1'b1, 1'b1, 12'h123, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        dones = 0;
        for (int k = 1; k <= 123; k++) begin
            cycle(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
            if (if0.done) dones++;
            check($sformatf("full_done_tick%0d", k), 0, 32'(if0.done), 32'(k == 123));
            if (k == 1) check("full_tick1", 0, 32'(if0.digits), 32'h122);
            if (k == 4) check("full_tick4", 0, 32'(if0.digits), 32'h119);
        end
        check("full_done_count", 0, 32'(dones), 32'd1);
        check("full_end_digits", 0, 32'(if0.digits), 32'h000);
        check("full_end_busy", 0, 32'(if0.busy), 32'd0);

        // Auto-reload period of three ticks
        cycle(1'b1, 1'b1, 12'h003, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            cycle(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
            check($sformatf("auto_digits_tick%0d", k), 1, 32'(if1.digits), 32'(3 - (k % 3)));
            check($sformatf("auto_done_tick%0d", k), 1, 32'(if1.done), 32'((k % 3) == 0));
            check($sformatf("auto_busy_tick%0d", k), 1, 32'(if1.busy), 32'd1);
        end

        // Reset in the middle of a run
        cycle(1'b1, 1'b1, 12'h050, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
        check("midrun_before_rst", 0, 32'(if0.digits), 32'h048);
        cycle(1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
        check("midrun_rst_digits", 0, 32'(if0.digits), 32'h000);
        check("midrun_rst_busy", 0, 32'(if0.busy), 32'd0);
        check("midrun_rst_digits", 1, 32'(if1.digits), 32'h000);
        check("midrun_rst_busy", 1, 32'(if1.busy), 32'd0);

        // Random one-hot stimulus against the reference model
        for (int c = 0; c < 3000; c++) begin
            int          sel;
            bit          rstn, ld, st, sp, en;
            logic [11:0] lv;
            sel  = int'($urandom_range(0, 99));
            rstn = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) begin
                lv = 12'($urandom);
            end else if ($urandom_range(0, 1) == 0) begin
                lv = int2bcd(int'($urandom_range(0, 12)));
            end else begin
                lv = int2bcd(int'($urandom_range(0, 999)));
            end
            ld = (sel < 4);
            sp = (sel >= 4) && (sel < 7);
            st = (sel >= 7) && (sel < 17);
            en = (sel >= 17) && (sel < 85);
            cycle(rstn, ld, lv, st, sp, en);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
